// File: rtl/alu_seq_if.sv
// Handshake and data bundle for the multi-cycle ALU.
// Valid/ready rule on both sides: a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds its payload stable while valid=1
// and ready=0. On the input side op/a/b are only looked at on the transfer edge.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  // Issuing side: drives operations, consumes results
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  // ALU side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MUL/DIVU/REMU
// (one bit per cycle), status flags {dz, v, c, n, z}.
// An op is taken when in_valid & in_ready; the result sits in DONE with out_valid=1
// until out_ready=1. in_ready is only high in IDLE, so the issuing stage stalls for
// the whole BUSY/DONE period.
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [1:0] state_dbg
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_TCP  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  localparam logic [WIDTH:0]     ONE_EXT  = (WIDTH + 1)'(1);
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;      // MUL: shifted multiplicand; DIV: dividend/quotient shift reg
  logic [WIDTH-1:0]   b_q;      // MUL: shifted multiplier;   DIV: divisor
  logic [WIDTH-1:0]   acc;      // MUL: partial product;      DIV: partial remainder
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   res_q;
  logic [4:0]         flags_q;

  logic accept;
  logic is_iter;

  assign accept  = bus.in_valid && (state == IDLE);
  assign is_iter = (bus.op == OP_MUL) || (bus.op == OP_DIVU) || (bus.op == OP_REMU);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  // Shifts carry one extra guard bit so the last bit shifted out falls into it;
  // with sh==0 the guard bit stays 0, giving c=0.
  // ---------------------------------------------------------------------------
  logic [SHAMT_W-1:0]      sh;
  logic [WIDTH:0]          add_ext;
  logic [WIDTH:0]          sub_ext;
  logic [WIDTH:0]          tcp_ext;
  logic [WIDTH:0]          shl_ext;
  logic [WIDTH:0]          srl_ext;
  logic signed [WIDTH:0]   sra_ext;
  logic [WIDTH-1:0]        sc_res;
  logic                    sc_c;
  logic                    sc_v;

  assign sh      = bus.b[SHAMT_W-1:0];
  assign add_ext = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + ONE_EXT;
  assign tcp_ext = {1'b0, ~bus.a} + ONE_EXT;
  assign shl_ext = {1'b0, bus.a} << sh;
  assign srl_ext = {bus.a, 1'b0} >> sh;
  assign sra_ext = $signed({bus.a, 1'b0}) >>> sh;

  // Result, carry and overflow of the single-cycle ops
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res = add_ext[MSB:0];
        sc_c   = add_ext[WIDTH];
        sc_v   = (bus.a[MSB] == bus.b[MSB]) && (add_ext[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        sc_res = sub_ext[MSB:0];
        sc_c   = sub_ext[WIDTH];
        sc_v   = (bus.a[MSB] != bus.b[MSB]) && (sub_ext[MSB] != bus.a[MSB]);
      end
      OP_AND: sc_res = bus.a & bus.b;
      OP_ORR: sc_res = bus.a | bus.b;
      OP_NOT: sc_res = ~bus.a;
      OP_TCP: begin
        sc_res = tcp_ext[MSB:0];
        sc_c   = tcp_ext[WIDTH];
        // only the most negative value stays negative after negation
        sc_v   = bus.a[MSB] && tcp_ext[MSB];
      end
      OP_SHL: begin
        sc_res = shl_ext[MSB:0];
        sc_c   = shl_ext[WIDTH];
      end
      OP_SRA: begin
        sc_res = sra_ext[WIDTH:1];
        sc_c   = sra_ext[0];
      end
      OP_SRL: begin
        sc_res = srl_ext[WIDTH:1];
        sc_c   = srl_ext[0];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative step logic. Restoring division with b==0 subtracts zero every
  // step, which naturally yields quotient all-ones and remainder a.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;
  logic [WIDTH-1:0] iter_res;
  logic             iter_dz;

  assign mul_acc_nxt = b_q[0] ? (acc + a_q) : acc;
  assign div_sh      = {acc, a_q[MSB]};
  assign div_ge      = (div_sh >= {1'b0, b_q});
  // the remainder is always below the divisor, so the low WIDTH bits are exact
  assign div_rem_nxt = div_ge ? (div_sh[MSB:0] - b_q) : div_sh[MSB:0];
  assign div_quo_nxt = {a_q[MSB-1:0], div_ge};

  assign iter_res = (op_q == OP_MUL)  ? mul_acc_nxt :
                    (op_q == OP_DIVU) ? div_quo_nxt : div_rem_nxt;
  assign iter_dz  = (op_q != OP_MUL) && (b_q == '0);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_iter ? BUSY : DONE;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result/flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
            acc  <= '0;
            cnt  <= CNT_LAST;
            if (!is_iter) begin
              res_q   <= sc_res;
              flags_q <= {1'b0, sc_v, sc_c, sc_res[MSB], (sc_res == '0)};
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (op_q == OP_MUL) begin
            acc <= mul_acc_nxt;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end else begin
            acc <= div_rem_nxt;
            a_q <= div_quo_nxt;
          end
          if (cnt == '0) begin
            res_q   <= iter_res;
            flags_q <= {iter_dz, 1'b0, 1'b0, iter_res[MSB], (iter_res == '0)};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.flags     = flags_q;
  assign state_dbg     = state;

endmodule
